// File: rtl/scene_sequencer_if.sv
// scene_sequencer_if: bundles the frame input, raw buttons and scene outputs of scene_sequencer.
//   frame       : frame counter from video_timer (resets to 32'hFFFF_FFFF)
//   btn_pause   : raw pause pushbutton, asynchronous
//   btn_next    : raw next-scene pushbutton, asynchronous
//   scene_sel   : active scene index
//   update      : one-cycle animation advance strobe
//   scene_reset : one-cycle strobe, new scene reloads its initial state
//   blank       : force RGB to 0
//   paused      : high while paused
// master drives frame/buttons, slave (the sequencer) drives the scene outputs.
interface scene_sequencer_if #(
    parameter int NUM_SCENES = 4
);
    localparam int SW = (NUM_SCENES > 1) ? $clog2(NUM_SCENES) : 1;
    logic [31:0]   frame;
    logic          btn_pause;
    logic          btn_next;
    logic [SW-1:0] scene_sel;
    logic          update;
    logic          scene_reset;
    logic          blank;
    logic          paused;
    modport master (
        output frame, btn_pause, btn_next,
        input  scene_sel, update, scene_reset, blank, paused
    );
    modport slave (
        input  frame, btn_pause, btn_next,
        output scene_sel, update, scene_reset, blank, paused
    );
endinterface

// File: rtl/scene_sequencer.sv
// scene_sequencer: frame-rate controller that strobes animation updates, rotates scenes and blanks around switches.
//   clk : pixel clock
//   rst : asynchronous active-high reset
//   bus : scene_sequencer_if.slave (frame, btn_pause, btn_next in; scene_sel, update, scene_reset, blank, paused out)
// Optional pause/next buttons are built when SCENE_SEQUENCER_BUTTONS_EN is defined;
// otherwise the button inputs are ignored and paused is tied to 0.
module scene_sequencer #(
    parameter int NUM_SCENES      = 4,
    parameter int DWELL_FRAMES    = 600,
    parameter int BLANK_FRAMES    = 8,
    parameter int SPEED_DIV       = 1,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input logic clk,
    input logic rst,
    scene_sequencer_if.slave bus
);
    localparam int SW  = (NUM_SCENES > 1) ? $clog2(NUM_SCENES) : 1;
    localparam int DWW = $clog2(DWELL_FRAMES + 1);
    localparam int DVW = $clog2(SPEED_DIV + 1);
    localparam int BLW = $clog2(BLANK_FRAMES + 1);
    localparam logic [SW-1:0]  SEL_MAX = SW'(NUM_SCENES - 1);
    localparam logic [DWW-1:0] DW_MAX  = DWW'(DWELL_FRAMES - 1);
    localparam logic [DVW-1:0] DV_MAX  = DVW'(SPEED_DIV - 1);
    localparam logic [BLW-1:0] BL_MAX  = BLW'(BLANK_FRAMES - 1);

    typedef enum logic [1:0] {RUN = 2'd0, BLANK = 2'd1, PAUSE = 2'd2} state_t;

    state_t         r_state, w_state_nx;
    logic [31:0]    r_frame_prev;
    logic [DWW-1:0] r_dwell, w_dwell_nx;
    logic [DVW-1:0] r_div, w_div_nx;
    logic [BLW-1:0] r_blank_cnt, w_blank_nx;
    logic [SW-1:0]  r_sel, w_sel_nx;
    logic           r_update, r_scene_reset, r_blank;
    logic           w_new_frame, w_switch, w_adv, w_update;
    logic           w_pause_evt, w_next_evt;

    assign w_new_frame = bus.frame != r_frame_prev;

`ifdef SCENE_SEQUENCER_BUTTONS_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
    // bit 1 = pause, bit 0 = next
    logic [1:0]     r_s1, r_s2, r_lvl, r_evt;
    logic [DBW-1:0] r_db_cnt [2];
    logic           r_paused;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_lvl    <= '0;
            r_evt    <= '0;
            r_paused <= 1'b0;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_s1     <= {bus.btn_pause, bus.btn_next};
            r_s2     <= r_s1;
            r_paused <= w_state_nx == PAUSE;
            for (int i = 0; i < 2; i++) begin
                // event only on an accepted rise of the debounced level
                r_evt[i] <= r_s2[i] && !r_lvl[i] && r_db_cnt[i] == DB_MAX;
                if (r_s2[i] == r_lvl[i])
                    r_db_cnt[i] <= '0;
                else if (r_db_cnt[i] == DB_MAX) begin
                    r_lvl[i]    <= r_s2[i];
                    r_db_cnt[i] <= '0;
                end else
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
        end
    end
    assign w_pause_evt = r_evt[1];
    assign w_next_evt  = r_evt[0];
    assign bus.paused  = r_paused;
`else
    logic w_unused;
    assign w_unused    = bus.btn_pause ^ bus.btn_next ^ (DEBOUNCE_CYCLES == 0);
    assign w_pause_evt = 1'b0;
    assign w_next_evt  = 1'b0;
    assign bus.paused  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nx;
    end

    // button events take priority over the frame tick in RUN, so that frame is skipped
    always_comb begin
        w_state_nx = r_state;
        w_switch   = 1'b0;
        w_adv      = 1'b0;
        case (r_state)
            RUN: begin
                if (w_next_evt) w_switch = 1'b1;
                else if (w_pause_evt) w_state_nx = PAUSE;
                else if (w_new_frame) begin
                    w_adv    = 1'b1;
                    w_switch = r_dwell == DW_MAX;
                end
            end
            BLANK: if (w_new_frame && r_blank_cnt == BL_MAX) w_state_nx = RUN;
            PAUSE: begin
                if (w_next_evt) w_switch = 1'b1;
                else if (w_pause_evt) w_state_nx = RUN;
            end
            default: w_state_nx = RUN;
        endcase
        if (w_switch) w_state_nx = BLANK;
    end

    always_comb begin
        w_update   = w_adv && r_div == DV_MAX;
        w_div_nx   = (w_switch || w_update) ? '0 : w_adv ? r_div + 1'b1 : r_div;
        w_dwell_nx = w_switch ? '0 : w_adv ? r_dwell + 1'b1 : r_dwell;
        w_blank_nx = w_switch ? '0 :
                     (r_state == BLANK && w_new_frame && r_blank_cnt != BL_MAX) ? r_blank_cnt + 1'b1 : r_blank_cnt;
        w_sel_nx   = !w_switch ? r_sel : (r_sel == SEL_MAX) ? '0 : r_sel + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_prev  <= '1;
            r_dwell       <= '0;
            r_div         <= '0;
            r_blank_cnt   <= '0;
            r_sel         <= '0;
            r_update      <= 1'b0;
            r_scene_reset <= 1'b0;
            r_blank       <= 1'b0;
        end else begin
            r_frame_prev  <= bus.frame;
            r_dwell       <= w_dwell_nx;
            r_div         <= w_div_nx;
            r_blank_cnt   <= w_blank_nx;
            r_sel         <= w_sel_nx;
            r_update      <= w_update;
            r_scene_reset <= w_switch;
            r_blank       <= w_state_nx == BLANK;
        end
    end

    assign bus.scene_sel   = r_sel;
    assign bus.update      = r_update;
    assign bus.scene_reset = r_scene_reset;
    assign bus.blank       = r_blank;
endmodule
